// File: rtl/reverse_substitution_if.sv
// Handshake bundle between reversediffusion, this stage, and the next AddRoundKey stage.
// The master drives states in and takes results out; the slave is the substitution stage.
interface reverse_substitution_if;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][3:0][7:0]  in_state;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0][3:0][7:0]  out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/reverse_substitution.sv
// Byte-serial InvShiftRows + InvSubBytes for the AES decryption path.
// One shared inverse S-box handles one byte per clock, 16 clocks per state.
module reverse_substitution #(
  parameter bit ENABLE_SHIFT = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  reverse_substitution_if.slave  bus,
  output logic                   busy
);
  // state | meaning
  // IDLE  | waiting for a state, in_ready high
  // BUSY  | writing one output byte per clock
  // DONE  | result held, out_valid high until consumed
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254, which also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0][3:0][7:0] cap_q, cap_d;
  logic [3:0][3:0][7:0] out_q, out_d;

  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] src_col;
  logic [7:0] sbox_out;

  // Storage index is 3-row / 3-col; the shift source column wraps in 2 bits.
  always_comb begin
    row      = cnt_q[1:0];
    col      = cnt_q[3:2];
    src_col  = ENABLE_SHIFT ? (col - row) : col;
    sbox_out = inv_sbox(cap_q[2'd3 - row][2'd3 - src_col]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap_d   = bus.in_state;
          cnt_d   = 4'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_d[2'd3 - row][2'd3 - col] = sbox_out;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = out_q;
  assign busy          = (state_q == BUSY);
endmodule

// File: tb/tb_reverse_substitution.sv
// Bench for reverse_substitution: shifted and bypass instances side by side, compared every
// cycle against a transaction-level model built on the FIPS-197 inverse S-box table.
module tb_reverse_substitution;
  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 tb_in_valid = 1'b0;
  logic                 tb_out_ready = 1'b0;
  logic [3:0][3:0][7:0] tb_in_state = '0;
  logic                 busy1, busy0;
  bit                   rand_rdy = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  reverse_substitution_if if1 ();
  reverse_substitution_if if0 ();

  assign if1.in_valid  = tb_in_valid;
  assign if1.in_state  = tb_in_state;
  assign if1.out_ready = tb_out_ready;
  assign if0.in_valid  = tb_in_valid;
  assign if0.in_state  = tb_in_state;
  assign if0.out_ready = tb_out_ready;

  reverse_substitution #(.ENABLE_SHIFT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1), .busy(busy1)
  );
  reverse_substitution #(.ENABLE_SHIFT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0), .busy(busy0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] inv_tab [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  int exp_sh [4][4] = '{'{0, 1, 2, 3}, '{3, 0, 1, 2}, '{2, 3, 0, 1}, '{1, 2, 3, 0}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [127:0] rowpat();
    logic [3:0][3:0][7:0] s;
    logic [7:0] pat [4];
    pat[0] = 8'h63; pat[1] = 8'h7c; pat[2] = 8'h77; pat[3] = 8'h7b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[3-r][3-c] = pat[c];
    return s;
  endfunction

  // AES (row, col) lives at [3-row][3-col]; InvShiftRows pulls from column (c - r) mod 4.
  function automatic logic [127:0] model_out(input logic [127:0] s, input bit shift);
    logic [3:0][3:0][7:0] cap;
    logic [3:0][3:0][7:0] res;
    cap = s;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int src;
        src = shift ? (c - r + 4) % 4 : c;
        res[3-r][3-c] = inv_tab[cap[3-r][3-src]];
      end
    return res;
  endfunction

  // Transaction model: index 0 = bypass instance, 1 = shifting instance.
  int           m_left  [2];
  bit           m_done  [2];
  logic [127:0] m_exp   [2];
  logic [127:0] m_shown [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_left[d]  <= 0;
        m_done[d]  <= 1'b0;
        m_shown[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_left[d] > 0) begin
          m_left[d] <= m_left[d] - 1;
          if (m_left[d] == 1) begin
            m_done[d]  <= 1'b1;
            m_shown[d] <= m_exp[d];
          end
        end else if (m_done[d]) begin
          if (tb_out_ready) m_done[d] <= 1'b0;
        end else if (tb_in_valid) begin
          m_exp[d]  <= model_out(tb_in_state, d == 1);
          m_left[d] <= 16;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready_shift",  if1.in_ready,  m_left[1] == 0 && !m_done[1]);
      chk("out_valid_shift", if1.out_valid, m_done[1]);
      chk("busy_shift",      busy1,         m_left[1] > 0);
      if (m_left[1] == 0) chk("out_state_shift", if1.out_state, m_shown[1]);
      chk("in_ready_bypass",  if0.in_ready,  m_left[0] == 0 && !m_done[0]);
      chk("out_valid_bypass", if0.out_valid, m_done[0]);
      chk("busy_bypass",      busy0,         m_left[0] > 0);
      if (m_left[0] == 0) chk("out_state_bypass", if0.out_state, m_shown[0]);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) tb_out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [127:0] s, input bit keep, output int acc_cyc);
    int waited;
    waited = 0;
    tb_in_state = s;
    tb_in_valid = 1'b1;
    while (!if1.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!if1.in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep) tb_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int valid_cyc, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (!if1.out_valid && n < 100) begin
      if (busy1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!if1.out_valid) chk("valid_timeout", 0, 1);
    valid_cyc = cyc;
  endtask

  initial begin
    int acc, acc2, vc, bc;
    logic [127:0] snap;
    logic [3:0][3:0][7:0] o1, o0;
    logic [7:0] in_b [3];
    logic [7:0] out_b [3];
    logic [127:0] rs;

    in_b[0] = 8'hc9; out_b[0] = 8'h12;
    in_b[1] = 8'hca; out_b[1] = 8'h10;
    in_b[2] = 8'h00; out_b[2] = 8'h52;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  if1.in_ready,  1);
    chk("rst_out_valid", if1.out_valid, 0);
    chk("rst_busy",      busy1,         0);
    chk("rst_out_state", if1.out_state, '0);
    reset_n = 1'b1;
    @(negedge clk);

    tb_out_ready = 1'b1;
    send(fill(8'h63), 1'b0, acc);
    wait_valid(vc, bc);
    chk("latency_63", vc - acc, 16);
    chk("busy_cycles_63", bc, 16);
    chk("all63_shift", if1.out_state, fill(8'h00));
    chk("all63_bypass", if0.out_state, fill(8'h00));
    @(negedge clk);
    chk("in_ready_after_hs", if1.in_ready, 1);

    send(rowpat(), 1'b0, acc);
    wait_valid(vc, bc);
    o1 = if1.out_state;
    o0 = if0.out_state;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rowpat_shift_r%0d_c%0d", r, c), o1[3-r][3-c], 8'(exp_sh[r][c]));
        chk($sformatf("rowpat_bypass_r%0d_c%0d", r, c), o0[3-r][3-c], 8'(c));
      end
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      send(fill(in_b[i]), 1'b0, acc);
      wait_valid(vc, bc);
      chk($sformatf("fill_%h_bypass", in_b[i]), if0.out_state, fill(out_b[i]));
      chk($sformatf("fill_%h_shift", in_b[i]), if1.out_state, fill(out_b[i]));
      @(negedge clk);
    end

    tb_out_ready = 1'b0;
    send(rowpat(), 1'b0, acc);
    wait_valid(vc, bc);
    snap = if1.out_state;
    for (int i = 0; i < 10; i++) begin
      tb_in_valid = 1'b1;
      tb_in_state = fill(8'h00);
      @(negedge clk);
      chk("bp_out_valid", if1.out_valid, 1);
      chk("bp_in_ready", if1.in_ready, 0);
      chk("bp_stable", if1.out_state, snap);
    end
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", if1.in_ready, 1);
    chk("bp_release_out_valid", if1.out_valid, 0);
    chk("bp_idle_hold", if1.out_state, snap);

    send(fill(8'h7c), 1'b0, acc);
    repeat (7) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", if1.out_valid, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_in_ready", if1.in_ready, 1);
    chk("arst_out_state", if1.out_state, '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    send(fill(8'h63), 1'b0, acc);
    wait_valid(vc, bc);
    chk("post_rst_latency", vc - acc, 16);
    chk("post_rst_all00", if1.out_state, fill(8'h00));
    @(negedge clk);

    send(fill(8'h63), 1'b1, acc);
    tb_in_state = fill(8'h7c);
    wait_valid(vc, bc);
    chk("b2b_first", if1.out_state, fill(8'h00));
    @(negedge clk);
    chk("b2b_first_valid_1cyc", if1.out_valid, 0);
    send(fill(8'h7c), 1'b0, acc2);
    chk("b2b_period", acc2 - acc, 18);
    wait_valid(vc, bc);
    chk("b2b_second", if1.out_state, fill(8'h01));
    @(negedge clk);
    chk("b2b_second_valid_1cyc", if1.out_valid, 0);

    rand_rdy = 1'b1;
    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int w = 0; w < 4; w++) rs[w*32 +: 32] = $urandom();
      send(rs, 1'b0, acc);
    end
    rand_rdy = 1'b0;
    tb_out_ready = 1'b1;
    repeat (25) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
